// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the multi-field timer.
// Fields are packed as {tens, units}, lowest field in the low byte.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] FIELD_MAX_LOW = 8'h59;
  localparam logic [7:0] FIELD_MAX_TOP = 8'h99;

  function automatic logic [3:0] bcd_inc(
    input logic [3:0] d,
    input logic [3:0] max
  );
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(
    input logic [3:0] d,
    input logic [3:0] max
  );
    return (d == 4'd0) ? max : d - 4'd1;
  endfunction

  function automatic logic [7:0] sanitise(
    input logic [7:0] v,
    input logic       top
  );
    logic [3:0] t, u, lim;
    lim = top ? FIELD_MAX_TOP[7:4] : FIELD_MAX_LOW[7:4];
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    t = (v[7:4] > lim) ? lim : v[7:4];
    return {t, u};
  endfunction

endpackage

// File: rtl/bcd_multi_timer_if.sv
// Control/status bundle between the button front end,
// the timer and the display scan driver.
interface bcd_multi_timer_if #(
  parameter int NUM_FIELDS = 2
);
  logic                    load;
  logic [8*NUM_FIELDS-1:0] set_bcd;
  logic                    start;
  logic                    pause;
  logic                    mode_down;
  logic [8*NUM_FIELDS-1:0] digits;
  logic [1:0]              state;
  logic                    tick_pulse;
  logic                    done_pulse;

  modport master (
    output load, set_bcd, start, pause, mode_down,
    input  digits, state, tick_pulse, done_pulse
  );

  modport slave (
    input  load, set_bcd, start, pause, mode_down,
    output digits, state, tick_pulse, done_pulse
  );
endinterface

// File: rtl/bcd_field.sv
// One two-digit BCD field with carry/borrow chaining.
// MAX_TENS is 5 for 00-59 fields and 9 for the top 00-99 field.
module bcd_field import timer_pkg::*; #(
  parameter logic [3:0] MAX_TENS = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic       down,
  input  logic       cin,
  output logic [7:0] digits,
  output logic       cout,
  output logic       is_zero,
  output logic       is_max
);
  logic [3:0] units_q, units_d;
  logic [3:0] tens_q, tens_d;
  logic       step;
  logic       units_wrap;

  assign is_zero = (tens_q == 4'd0) && (units_q == 4'd0);
  assign is_max  = (tens_q == MAX_TENS) && (units_q == 4'd9);
  assign step    = en & cin;
  assign cout    = step & (down ? is_zero : is_max);
  assign digits  = {tens_q, units_q};

  assign units_wrap = down ? (units_q == 4'd0)
                           : (units_q == 4'd9);

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    if (load) begin
      {tens_d, units_d} = load_val;
    end else if (step) begin
      units_d = down ? bcd_dec(units_q, 4'd9)
                     : bcd_inc(units_q, 4'd9);
      if (units_wrap)
        tens_d = down ? bcd_dec(tens_q, MAX_TENS)
                      : bcd_inc(tens_q, MAX_TENS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      units_q <= '0;
      tens_q  <= '0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
    end
  end

endmodule

// File: rtl/bcd_multi_timer.sv
// Cascaded BCD timer/stopwatch: prescaler, run/pause/done FSM,
// and a chain of bcd_field counters.
module bcd_multi_timer import timer_pkg::*; #(
  parameter int NUM_FIELDS = 2,
  parameter int TICK_DIV   = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  bcd_multi_timer_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  state_t                  state_q, state_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic                    mode_q, mode_d;
  logic                    tick_q, tick_d;
  logic                    done_q, done_d;
  logic [NUM_FIELDS-1:0]   zero_f, max_f, carry;
  logic [8*NUM_FIELDS-1:0] cnt;
  logic                    tick, step, load_en;
  logic                    term_now, term_next;
  logic                    unused_cout;

  assign unused_cout = carry[NUM_FIELDS-1];

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
    localparam logic [3:0] MT = (i == NUM_FIELDS - 1)
      ? FIELD_MAX_TOP[7:4] : FIELD_MAX_LOW[7:4];
    logic       cin;
    logic [7:0] lv;
    if (i == 0) begin : g_c0
      assign cin = 1'b1;
    end else begin : g_cn
      assign cin = carry[i-1];
    end
    assign lv = sanitise(bus.set_bcd[8*i +: 8],
                         1'(i == NUM_FIELDS - 1));
    bcd_field #(.MAX_TENS(MT)) u_field (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_en),
      .load_val (lv),
      .en       (step),
      .down     (mode_q),
      .cin      (cin),
      .digits   (cnt[8*i +: 8]),
      .cout     (carry[i]),
      .is_zero  (zero_f[i]),
      .is_max   (max_f[i])
    );
  end

  assign tick = (state_q == RUN) && (pre_q == PMAX);

  assign term_now = bus.mode_down ? &zero_f : &max_f;

  // Look one step ahead so DONE lands with the final update.
  assign term_next = mode_q
    ? (cnt[7:0] == 8'h01) && (&zero_f[NUM_FIELDS-1:1])
    : (cnt[7:0] == 8'h58) && (&max_f[NUM_FIELDS-1:1]);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    step    = 1'b0;
    load_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.pause) begin
          if (bus.load) begin
            load_en = 1'b1;
          end else if (bus.start) begin
            mode_d = bus.mode_down;
            pre_d  = '0;
            if (term_now) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
      end
      RUN: begin
        if (bus.pause) begin
          state_d = PAUSED;
        end else if (tick) begin
          step   = 1'b1;
          tick_d = 1'b1;
          pre_d  = '0;
          if (term_next) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      PAUSED: begin
        if (!bus.pause) begin
          if (bus.load) begin
            load_en = 1'b1;
            state_d = IDLE;
          end else if (bus.start) begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        if (!bus.pause && bus.load) begin
          load_en = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      mode_q  <= 1'b1;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign bus.digits     = cnt;
  assign bus.state      = state_q;
  assign bus.tick_pulse = tick_q;
  assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_bcd_multi_timer.sv
// Scoreboarded bench: mm:ss at TICK_DIV=1 and hh:mm:ss at
// TICK_DIV=4, expected counts derived from integer seconds.
module tb_bcd_multi_timer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_multi_timer_if #(.NUM_FIELDS(2)) ia();
  bcd_multi_timer_if #(.NUM_FIELDS(3)) ib();

  bcd_multi_timer #(.NUM_FIELDS(2), .TICK_DIV(1)) ua (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );
  bcd_multi_timer #(.NUM_FIELDS(3), .TICK_DIV(4)) ub (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  int vec = 0;
  int miss = 0;
  logic [31:0] exp_q[$];

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] to_bcd(input int v, input int nf);
    logic [31:0] r;
    int rem, f;
    r = '0;
    rem = v;
    for (int i = 0; i < nf; i++) begin
      if (i < nf - 1) begin
        f = rem % 60;
        rem = rem / 60;
      end else begin
        f = rem % 100;
      end
      r[8*i +: 8] = 8'((f / 10) * 16 + (f % 10));
    end
    return r;
  endfunction

  task automatic clr();
    ia.load = 0; ia.start = 0; ia.pause = 0;
    ia.mode_down = 0; ia.set_bcd = '0;
    ib.load = 0; ib.start = 0; ib.pause = 0;
    ib.mode_down = 0; ib.set_bcd = '0;
  endtask

  task automatic pop_a(input string nm);
    logic [31:0] e;
    vec++;
    if (exp_q.size() == 0) begin
      miss++;
      $display("FAIL %s: scoreboard empty, got %h", nm, ia.digits);
    end else begin
      e = exp_q.pop_front();
      if (ia.digits !== e[15:0]) begin
        miss++;
        $display("FAIL %s: got %h want %h", nm, ia.digits, e[15:0]);
      end
    end
  endtask

  task automatic pop_b(input string nm);
    logic [31:0] e;
    vec++;
    if (exp_q.size() == 0) begin
      miss++;
      $display("FAIL %s: scoreboard empty, got %h", nm, ib.digits);
    end else begin
      e = exp_q.pop_front();
      if (ib.digits !== e[23:0]) begin
        miss++;
        $display("FAIL %s: got %h want %h", nm, ib.digits, e[23:0]);
      end
    end
  endtask

  task automatic test_reset();
    clr();
    rst_n = 0;
    repeat (3) tk();
    vec++;
    if ({ia.digits, ia.state, ia.tick_pulse, ia.done_pulse} !== 20'h0) begin
      miss++;
      $display("FAIL reset_a: got %h/%0d want 0000/0", ia.digits, ia.state);
    end
    vec++;
    if ({ib.digits, ib.state, ib.tick_pulse, ib.done_pulse} !== 28'h0) begin
      miss++;
      $display("FAIL reset_b: got %h/%0d want 000000/0", ib.digits, ib.state);
    end
    rst_n = 1;
    tk();
  endtask

  task automatic test_countdown();
    int dones = 0;
    int ticks = 0;
    ia.set_bcd = 16'h0100; ia.load = 1; tk(); ia.load = 0;
    vec++;
    if (ia.digits !== 16'h0100) begin
      miss++; $display("FAIL load_0100: got %h want 0100", ia.digits);
    end
    ia.mode_down = 1; ia.start = 1; tk(); ia.start = 0;
    vec++;
    if (ia.state !== 2'd1) begin
      miss++; $display("FAIL start_run: got %0d want 1", ia.state);
    end
    for (int k = 1; k <= 60; k++) exp_q.push_back(to_bcd(60 - k, 2));
    for (int c = 0; c < 200 && ia.state != 2'd3; c++) begin
      tk();
      if (ia.done_pulse) dones++;
      if (ia.tick_pulse) begin
        ticks++;
        pop_a("down_tick");
      end
    end
    vec++;
    if (ia.state !== 2'd3 || ticks != 60) begin
      miss++;
      $display("FAIL down_done: state %0d ticks %0d want 3/60", ia.state, ticks);
    end
    vec++;
    if (dones != 1) begin
      miss++; $display("FAIL down_done_cnt: got %0d want 1", dones);
    end
    tk();
    vec++;
    if (ia.done_pulse !== 1'b0 || ia.digits !== 16'h0000 || ia.state !== 2'd3) begin
      miss++;
      $display("FAIL down_hold: got %b %h %0d want 0 0000 3", ia.done_pulse, ia.digits, ia.state);
    end
  endtask

  task automatic test_zero_start();
    ia.set_bcd = 16'h0000; ia.load = 1; tk(); ia.load = 0;
    vec++;
    if (ia.state !== 2'd0) begin
      miss++; $display("FAIL done_load_idle: got %0d want 0", ia.state);
    end
    ia.mode_down = 1; ia.start = 1; tk(); ia.start = 0;
    vec++;
    if (ia.state !== 2'd3 || ia.done_pulse !== 1'b1 || ia.tick_pulse !== 1'b0) begin
      miss++;
      $display("FAIL zero_start: got st %0d dp %b tp %b want 3 1 0", ia.state, ia.done_pulse, ia.tick_pulse);
    end
    tk();
    vec++;
    if (ia.done_pulse !== 1'b0) begin
      miss++; $display("FAIL zero_dp_once: got %b want 0", ia.done_pulse);
    end
  endtask

  task automatic test_count_up();
    ia.set_bcd = 16'h9958; ia.load = 1; tk(); ia.load = 0;
    ia.mode_down = 0; ia.start = 1; tk(); ia.start = 0;
    vec++;
    if (ia.state !== 2'd1) begin
      miss++; $display("FAIL up_run: got %0d want 1", ia.state);
    end
    exp_q.push_back(to_bcd(99 * 60 + 59, 2));
    tk();
    pop_a("up_tick");
    vec++;
    if (ia.state !== 2'd3 || ia.done_pulse !== 1'b1 || ia.tick_pulse !== 1'b1) begin
      miss++;
      $display("FAIL up_done: got st %0d dp %b tp %b want 3 1 1", ia.state, ia.done_pulse, ia.tick_pulse);
    end
    ia.start = 1; ia.pause = 1; tk(); ia.start = 0; ia.pause = 0;
    vec++;
    if (ia.state !== 2'd3 || ia.digits !== 16'h9959 || ia.done_pulse !== 1'b0) begin
      miss++;
      $display("FAIL up_hold: got %0d %h %b want 3 9959 0", ia.state, ia.digits, ia.done_pulse);
    end
  endtask

  task automatic test_pause_resume();
    logic bad = 1'b0;
    ib.set_bcd = 24'h010000; ib.load = 1; tk(); ib.load = 0;
    ib.mode_down = 1; ib.start = 1; tk(); ib.start = 0;
    repeat (3) tk();
    vec++;
    if (ib.digits !== 24'h010000 || ib.tick_pulse !== 1'b0) begin
      miss++; $display("FAIL early_tick: got %h want 010000", ib.digits);
    end
    exp_q.push_back(to_bcd(3599, 3));
    tk();
    pop_b("first_tick");
    tk(); tk();
    ib.pause = 1; tk(); ib.pause = 0;
    vec++;
    if (ib.state !== 2'd2) begin
      miss++; $display("FAIL pause: got %0d want 2", ib.state);
    end
    for (int c = 0; c < 10; c++) begin
      tk();
      if (ib.digits !== 24'h005959 || ib.tick_pulse !== 1'b0) bad = 1'b1;
    end
    vec++;
    if (bad) begin
      miss++; $display("FAIL paused_hold: got %h want 005959", ib.digits);
    end
    ib.start = 1; tk(); ib.start = 0;
    tk();
    vec++;
    if (ib.digits !== 24'h005959 || ib.state !== 2'd1) begin
      miss++; $display("FAIL resume_wait: got %h/%0d want 005959/1", ib.digits, ib.state);
    end
    exp_q.push_back(to_bcd(3598, 3));
    tk();
    vec++;
    if (ib.tick_pulse !== 1'b1) begin
      miss++; $display("FAIL resume_frac: tick_pulse got %b want 1", ib.tick_pulse);
    end
    pop_b("resume_tick");
  endtask

  task automatic test_start_pause_same();
    ib.start = 1; ib.pause = 1; tk(); ib.start = 0; ib.pause = 0;
    vec++;
    if (ib.state !== 2'd2 || ib.digits !== 24'h005958) begin
      miss++; $display("FAIL start_pause: got %0d %h want 2 005958", ib.state, ib.digits);
    end
  endtask

  task automatic test_sanitise();
    ib.set_bcd = 24'hFF7AFF; ib.load = 1; tk();
    vec++;
    if (ib.digits !== 24'h995959 || ib.state !== 2'd0) begin
      miss++; $display("FAIL sanitise_ff: got %h/%0d want 995959/0", ib.digits, ib.state);
    end
    ib.set_bcd = 24'h5C3B60; tk();
    vec++;
    if (ib.digits !== 24'h593950) begin
      miss++; $display("FAIL sanitise_mix: got %h want 593950", ib.digits);
    end
    ib.set_bcd = 24'hFF7AFF; tk(); ib.load = 0;
    ib.mode_down = 1; ib.start = 1; tk(); ib.start = 0;
    ib.set_bcd = 24'h000000; ib.load = 1; tk(); ib.load = 0;
    vec++;
    if (ib.digits !== 24'h995959 || ib.state !== 2'd1) begin
      miss++; $display("FAIL run_load_ignored: got %h/%0d want 995959/1", ib.digits, ib.state);
    end
    tk(); tk();
    exp_q.push_back(to_bcd(99 * 3600 + 59 * 60 + 58, 3));
    tk();
    pop_b("top_tick");
  endtask

  task automatic test_reset_mid();
    int dp = 0;
    tk(); tk();
    #2 rst_n = 0;
    #1;
    vec++;
    if (ib.digits !== 24'h0 || ib.state !== 2'd0) begin
      miss++; $display("FAIL async_rst: got %h/%0d want 000000/0", ib.digits, ib.state);
    end
    repeat (3) begin
      tk();
      if (ib.done_pulse) dp++;
    end
    rst_n = 1;
    repeat (3) begin
      tk();
      if (ib.done_pulse) dp++;
    end
    vec++;
    if (dp != 0 || ib.state !== 2'd0 || ib.digits !== 24'h0) begin
      miss++; $display("FAIL rst_no_done: dp %0d st %0d want 0 0", dp, ib.state);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_zero_start();
    test_count_up();
    test_pause_resume();
    test_start_pause_same();
    test_sanitise();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
